weight_buffer_multibank: RTL and testbench
==========================================

# weight_buffer_multibank

Parametrised multi-bank weight buffer, the next generation of the two-bank ping-pong weight memory in the MAC engine. It holds `N_BANKS` identical weight banks managed as a circular queue. An external loader fills one bank while the PE array reads another. Bank ownership is explicit through commit/release handshakes instead of address-MSB selection. It serves FC reads (N×N tile) and CNN reads (one N-wide row) from the same storage with one-cycle read latency.

## Interface
Parameters:
- `N_DIM`, 4: PE array dimension; power of two, ≥2.
- `DATA_W`, 8: signed weight width.
- `DEPTH`, 256: rows per bank, each row `N_DIM` weights; power of two, multiple of `N_DIM`.
- `N_BANKS`, 2: number of banks; 2..8.
- Derived: `AW = $clog2(DEPTH)`, `BW = max(1, $clog2(N_BANKS))`, `CW = $clog2(N_BANKS+1)`.

Ports:
- `clk`  in  1  clock; one clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `mode`  in  1  0 = FC, 1 = CNN; sampled with `rd_en`.
- `wr_valid`  in  1  write one row into the current fill bank.
- `wr_ready`  out  1  a fill bank is available (`count < N_BANKS`).
- `wr_addr`  in  AW  row address within the fill bank.
- `wr_data`  in  [N_DIM][DATA_W]  row data.
- `wr_commit`  in  1  pulse: fill bank complete, hand it to the reader.
- `rd_en`  in  1  read request on the current read bank.
- `rd_addr`  in  AW  row address. In FC mode the low `$clog2(N_DIM)` bits are ignored.
- `rd_release`  in  1  pulse: reader finished with the read bank.
- `rd_bank_ready`  out  1  `count > 0`.
- `rd_valid`  out  1  `rd_data` updated this cycle.
- `rd_data`  out  [N_DIM][N_DIM][DATA_W]  read tile.
- `fill_bank`, `read_bank`  out  BW  current bank indices.
- `count`  out  CW  committed, unreleased banks.
- `err`  out  1  sticky protocol-error flag.

## Operation
- **Queue state:**
  - `rd_ptr` in 0..N_BANKS-1; `count` in 0..N_BANKS.
  - `read_bank = rd_ptr`.
  - `fill_bank = (rd_ptr + count) mod N_BANKS`, with explicit wrap, so any `N_BANKS` works.
- **Write:**
  - When `wr_valid && wr_ready`, row `wr_addr` of `fill_bank` is written.
  - Row r goes to lane `r mod N_DIM`, index `r / N_DIM`.
- **Commit:** `wr_commit && count < N_BANKS` increments `count`.
- **Release:** `rd_release && count > 0` decrements `count` and advances `rd_ptr` with wrap.
- **Simultaneous commit and release:** `count` is unchanged and `rd_ptr` advances. `fill_bank` is recomputed from the new values.
- **Read, FC mode:** `rd_data[i][k]` = weight k of row `(rd_addr & ~(N_DIM-1)) + i`, for all i and k.
- **Read, CNN mode:** `rd_data[0][k]` = weight k of row `rd_addr`; all other rows are 0.
- **Same-cycle write and commit:** the write lands in the pre-commit fill bank.
- **Same-cycle read and release:** the read uses the pre-release `rd_ptr`.
- **Protocol errors.** Each of these is ignored with no state change and sets `err`:
  - `wr_valid` while `!wr_ready`;
  - `wr_commit` at `count == N_BANKS`;
  - `rd_release` at `count == 0`;
  - `rd_en` at `count == 0`, which also gives no `rd_valid`.
- `err` clears only on reset.
- A write to the read bank is impossible by construction. Reading a bank while it fills is likewise impossible.

## Timing
- **Write:** the row is visible to a read issued one cycle after the write.
- **Read latency:** 1 cycle. `rd_valid` is high in the cycle after an accepted `rd_en`. `rd_data` holds its value until the next accepted read.
- **Handshake outputs:** `wr_ready`, `rd_bank_ready`, `fill_bank`, `read_bank` and `count` are registered-state derived. They update in the cycle after a commit or release edge.
- **Reset values:**
  - `count = 0`, `rd_ptr = 0`, so `wr_ready = 1`, `rd_bank_ready = 0`, `fill_bank = 0`, `read_bank = 0`;
  - `rd_valid = 0`, `rd_data = 0`, `err = 0`.
- **Reset behaviour:**
  - Storage contents are not cleared.
  - Reset mid-fill or mid-read discards all ownership; no `rd_valid` appears after reset for a read issued in the reset cycle.
- **Throughput:** one row write and one read per cycle concurrently, to different banks.

## Structure
- Shared package `parameters` gains `MODE_FC` / `MODE_CNN` constants for the 1-bit mode (if absent) and the `wb_row_t` typedef (`logic signed [N_DIM-1:0][DATA_W-1:0]`).
- Sub-module `weight_bank_lanes`: one bank as `N_DIM` 1R1W lane arrays of depth `DEPTH/N_DIM`. It has a per-lane read address and a registered read output, and is instantiated `N_BANKS` times via generate.
- Top level contains:
  - queue pointer/count logic;
  - write/read bank decode;
  - FC/CNN lane address generation;
  - output mux on the registered bank select;
  - error flag.

## Test plan
Bench parameters: N_DIM=4, DATA_W=8, DEPTH=16, N_BANKS=2.

1. **Reset and idle:** after reset, `wr_ready=1`, `rd_bank_ready=0`, `count=0`, `err=0`, `rd_data=0`. `rd_en` in this state sets `err=1` and gives no `rd_valid`.
2. **Fill and read bank 0:** fill rows 0..15 with value 16·r+k, then commit. Check `count=1`, `fill_bank=1`, `read_bank=0`.
   - FC read, `rd_addr=5`: next cycle `rd_valid=1` and `rd_data[i][k] = 16·(4+i)+k`.
   - CNN read, `rd_addr=6`: `rd_data[0] = {96, 97, 98, 99}` in k order; rows 1..3 are 0.
3. **Overlap:** read bank 0 every cycle while filling bank 1 with distinct values (rows `0x80+r`). Release bank 0 in the same cycle as committing bank 1: `count` stays 1, `read_bank=1`, and the next read returns bank-1 data.
4. **Full:** commit both banks → `count=2`, `wr_ready=0`. Then `wr_valid` → write dropped (bank contents unchanged on readback) and `err=1`. A third commit is ignored.
5. **Wrap with N_BANKS=3** (re-parameterised): six commit/release cycles. `read_bank` sequence is 0,1,2,0,1,2 and `fill_bank` is always `(read_bank+count) mod 3`.
6. **Reset mid-operation:** with `count=2` and `rd_en` high, assert reset for one cycle. Then `count=0`, `rd_valid=0`, `err=0`, and no stale `rd_valid` appears after reset.

Source files
------------

// File: rtl/weight_buffer_multibank_pkg.sv
// Shared definitions for the multi-bank weight buffer.
// Contents: the 1-bit read mode encodings and a modulo-wrap helper for bank indices.
package weight_buffer_multibank_pkg;

    localparam logic MODE_FC  = 1'b0;
    localparam logic MODE_CNN = 1'b1;

    // (a + b) mod n for a < n, b <= n, so the sum needs at most one subtraction.
    function automatic int unsigned wrap_add(input int unsigned a, input int unsigned b,
                                             input int unsigned n);
        int unsigned s;
        s = a + b;
        if (s >= n) begin
            s = s - n;
        end
        return s;
    endfunction

endpackage

// File: rtl/weight_buffer_multibank_lanes.sv
// One weight bank: N_DIM lane arrays, each of depth DEPTH/N_DIM. Row r is stored in
// lane r mod N_DIM at index r / N_DIM. Each lane has its own read index and a
// registered read output that holds its value until the next read enable.
// Ports: clk; i_wr_en/i_wr_addr/i_wr_data row write; i_rd_en/i_rd_idx per-lane read;
//        o_rd_lane registered lane outputs (lane-major).
module weight_bank_lanes #(
    parameter int unsigned N_DIM  = 4,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 256,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned LB    = $clog2(N_DIM),
    localparam int unsigned LD    = DEPTH / N_DIM,
    localparam int unsigned LAW   = (LD > 1) ? $clog2(LD) : 1
) (
    input  logic                                      clk,
    input  logic                                      i_wr_en,
    input  logic [AW-1:0]                             i_wr_addr,
    input  logic [N_DIM-1:0][DATA_W-1:0]              i_wr_data,
    input  logic                                      i_rd_en,
    input  logic [N_DIM-1:0][LAW-1:0]                 i_rd_idx,
    output logic [N_DIM-1:0][N_DIM-1:0][DATA_W-1:0]   o_rd_lane
);

    logic [LB-1:0]  w_wr_lane;
    logic [LAW-1:0] w_wr_idx;

    assign w_wr_lane = i_wr_addr[LB-1:0];
    assign w_wr_idx  = LAW'(i_wr_addr >> LB);

    for (genvar l = 0; l < N_DIM; l++) begin : g_lane
        logic [N_DIM-1:0][DATA_W-1:0] r_mem [LD];

        // 1R1W lane array with registered read port
        always_ff @(posedge clk) begin
            if (i_wr_en && (w_wr_lane == LB'(l))) begin
                r_mem[w_wr_idx] <= i_wr_data;
            end
            if (i_rd_en) begin
                o_rd_lane[l] <= r_mem[i_rd_idx[l]];
            end
        end
    end

endmodule

// File: rtl/weight_buffer_multibank.sv
// Multi-bank weight buffer managed as a circular queue of banks. The loader fills
// bank (rd_ptr + count) mod N_BANKS and hands it over with wr_commit; the PE array
// reads bank rd_ptr and returns it with rd_release. FC reads return an N_DIM x N_DIM
// tile of aligned rows, CNN reads return one row in rd_data[0]; latency is one cycle.
// Ports: clk, reset (sync, active-high); write side wr_valid/wr_ready/wr_addr/
//        wr_data/wr_commit; read side mode/rd_en/rd_addr/rd_release/rd_bank_ready/
//        rd_valid/rd_data; status fill_bank/read_bank/count/err (sticky).
module weight_buffer_multibank
    import weight_buffer_multibank_pkg::*;
#(
    parameter int unsigned N_DIM   = 4,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned DEPTH   = 256,
    parameter int unsigned N_BANKS = 2,
    localparam int unsigned AW     = $clog2(DEPTH),
    localparam int unsigned BW     = ($clog2(N_BANKS) > 1) ? $clog2(N_BANKS) : 1,
    localparam int unsigned CW     = $clog2(N_BANKS + 1)
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          mode,
    input  logic                                          wr_valid,
    output logic                                          wr_ready,
    input  logic [AW-1:0]                                 wr_addr,
    input  logic signed [N_DIM-1:0][DATA_W-1:0]           wr_data,
    input  logic                                          wr_commit,
    input  logic                                          rd_en,
    input  logic [AW-1:0]                                 rd_addr,
    input  logic                                          rd_release,
    output logic                                          rd_bank_ready,
    output logic                                          rd_valid,
    output logic signed [N_DIM-1:0][N_DIM-1:0][DATA_W-1:0] rd_data,
    output logic [BW-1:0]                                 fill_bank,
    output logic [BW-1:0]                                 read_bank,
    output logic [CW-1:0]                                 count,
    output logic                                          err
);

    localparam int unsigned LB  = $clog2(N_DIM);
    localparam int unsigned LD  = DEPTH / N_DIM;
    localparam int unsigned LAW = (LD > 1) ? $clog2(LD) : 1;

    logic [BW-1:0]  r_rd_ptr;
    logic [CW-1:0]  r_count;
    logic           r_err;
    logic           r_rd_valid;
    logic           r_rd_seen;
    logic [BW-1:0]  r_rd_bank;
    logic           r_rd_mode;
    logic [LB-1:0]  r_rd_lane;

    logic           w_wr_ready;
    logic           w_rd_ready;
    logic [BW-1:0]  w_fill_bank;
    logic           w_wr_acc;
    logic           w_rd_acc;
    logic           w_commit_ok;
    logic           w_rel_ok;
    logic           w_proto_err;
    logic [LAW-1:0] w_rd_idx;
    logic [N_DIM-1:0][N_DIM-1:0][DATA_W-1:0] w_bank_rd [N_BANKS];
    logic [N_DIM-1:0][N_DIM-1:0][DATA_W-1:0] w_rd_data;

    // Queue-derived handshake state
    assign w_wr_ready  = (r_count < CW'(N_BANKS));
    assign w_rd_ready  = (r_count != '0);
    assign w_fill_bank = BW'(wrap_add(32'(r_rd_ptr), 32'(r_count), N_BANKS));

    assign w_wr_acc    = wr_valid   && w_wr_ready && !reset;
    assign w_rd_acc    = rd_en      && w_rd_ready && !reset;
    assign w_commit_ok = wr_commit  && w_wr_ready;
    assign w_rel_ok    = rd_release && w_rd_ready;
    assign w_proto_err = (wr_valid && !w_wr_ready) || (wr_commit && !w_wr_ready) ||
                         (rd_release && !w_rd_ready) || (rd_en && !w_rd_ready);

    // FC and CNN both address the same lane index; they differ only in which lanes are used.
    assign w_rd_idx = LAW'(rd_addr >> LB);

    for (genvar b = 0; b < N_BANKS; b++) begin : g_bank
        weight_bank_lanes #(
            .N_DIM  (N_DIM),
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_bank (
            .clk       (clk),
            .i_wr_en   (w_wr_acc && (w_fill_bank == BW'(b))),
            .i_wr_addr (wr_addr),
            .i_wr_data (wr_data),
            .i_rd_en   (w_rd_acc && (r_rd_ptr == BW'(b))),
            .i_rd_idx  ({N_DIM{w_rd_idx}}),
            .o_rd_lane (w_bank_rd[b])
        );
    end

    // Output mux on the registered read context; zero until the first read after reset.
    always_comb begin
        w_rd_data = '0;
        if (r_rd_seen) begin
            if (r_rd_mode == MODE_CNN) begin
                w_rd_data[0] = w_bank_rd[r_rd_bank][r_rd_lane];
            end else begin
                w_rd_data = w_bank_rd[r_rd_bank];
            end
        end
    end

    // Queue pointer/count, read context and sticky error flag
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_err      <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_seen  <= 1'b0;
            r_rd_bank  <= '0;
            r_rd_mode  <= MODE_FC;
            r_rd_lane  <= '0;
        end else begin
            r_rd_valid <= w_rd_acc;
            if (w_rd_acc) begin
                r_rd_seen <= 1'b1;
                r_rd_bank <= r_rd_ptr;
                r_rd_mode <= mode;
                r_rd_lane <= rd_addr[LB-1:0];
            end
            if (w_rel_ok) begin
                r_rd_ptr <= BW'(wrap_add(32'(r_rd_ptr), 32'd1, N_BANKS));
            end
            if (w_commit_ok && !w_rel_ok) begin
                r_count <= r_count + CW'(1);
            end else if (w_rel_ok && !w_commit_ok) begin
                r_count <= r_count - CW'(1);
            end
            if (w_proto_err) begin
                r_err <= 1'b1;
            end
        end
    end

    assign wr_ready      = w_wr_ready;
    assign rd_bank_ready = w_rd_ready;
    assign fill_bank     = w_fill_bank;
    assign read_bank     = r_rd_ptr;
    assign count         = r_count;
    assign err           = r_err;
    assign rd_valid      = r_rd_valid;
    assign rd_data       = w_rd_data;

endmodule

// File: tb/tb_weight_buffer_multibank.sv
// Self-checking bench for weight_buffer_multibank (N_DIM=4, DATA_W=8, DEPTH=16) with a
// two-bank instance for data-path scenarios and a three-bank instance for queue wrap.
module tb_weight_buffer_multibank;

    localparam int NB = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                     reset = 1'b0, mode = 1'b0, wr_valid = 1'b0, wr_commit = 1'b0;
    logic                     rd_en = 1'b0, rd_release = 1'b0;
    logic [3:0]               wr_addr = '0, rd_addr = '0;
    logic signed [3:0][7:0]   wr_data = '0;
    logic                     wr_ready, rd_bank_ready, rd_valid, err;
    logic signed [3:0][3:0][7:0] rd_data;
    logic [0:0]               fill_bank, read_bank;
    logic [1:0]               count;

    logic                     c3_commit = 1'b0, c3_release = 1'b0, c3_zero = 1'b0;
    logic [3:0]               c3_addr = '0;
    logic signed [3:0][7:0]   c3_data = '0;
    logic                     wr_ready_3, rd_bank_ready_3, rd_valid_3, err_3;
    logic signed [3:0][3:0][7:0] rd_data_3;
    logic [1:0]               fill_bank_3, read_bank_3, count_3;

    weight_buffer_multibank #(.N_DIM(4), .DATA_W(8), .DEPTH(16), .N_BANKS(2)) dut (
        .clk(clk), .reset(reset), .mode(mode), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data), .wr_commit(wr_commit), .rd_en(rd_en),
        .rd_addr(rd_addr), .rd_release(rd_release), .rd_bank_ready(rd_bank_ready),
        .rd_valid(rd_valid), .rd_data(rd_data), .fill_bank(fill_bank),
        .read_bank(read_bank), .count(count), .err(err)
    );

    weight_buffer_multibank #(.N_DIM(4), .DATA_W(8), .DEPTH(16), .N_BANKS(3)) dut3 (
        .clk(clk), .reset(reset), .mode(c3_zero), .wr_valid(c3_zero), .wr_ready(wr_ready_3),
        .wr_addr(c3_addr), .wr_data(c3_data), .wr_commit(c3_commit), .rd_en(c3_zero),
        .rd_addr(c3_addr), .rd_release(c3_release), .rd_bank_ready(rd_bank_ready_3),
        .rd_valid(rd_valid_3), .rd_data(rd_data_3), .fill_bank(fill_bank_3),
        .read_bank(read_bank_3), .count(count_3), .err(err_3)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: bank contents and queue state kept as plain arrays/integers.
    logic [7:0]               m_mem [NB][16][4];
    int                       m_count = 0, m_ptr = 0;
    logic                     m_err = 1'b0;
    logic                     exp_valid = 1'b0;
    logic signed [3:0][3:0][7:0] exp_data = '0;
    int                       m3_count = 0, m3_ptr = 0;

    // Apply the current inputs for one clock, advance the model from the pre-edge state.
    task automatic step();
        int  fb, base;
        bit  c_ok, r_ok;
        fb = (m_ptr + m_count) % NB;
        if (reset) begin
            m_count = 0; m_ptr = 0; m_err = 1'b0; exp_valid = 1'b0; exp_data = '0;
            m3_count = 0; m3_ptr = 0;
        end else begin
            exp_valid = 1'b0;
            if (rd_en) begin
                if (m_count > 0) begin
                    exp_valid = 1'b1;
                    exp_data  = '0;
                    if (mode) begin
                        for (int k = 0; k < 4; k++) exp_data[0][k] = m_mem[m_ptr][int'(rd_addr)][k];
                    end else begin
                        base = int'(rd_addr) / 4 * 4;
                        for (int i = 0; i < 4; i++)
                            for (int k = 0; k < 4; k++) exp_data[i][k] = m_mem[m_ptr][base + i][k];
                    end
                end else m_err = 1'b1;
            end
            if (wr_valid) begin
                if (m_count < NB) for (int k = 0; k < 4; k++) m_mem[fb][int'(wr_addr)][k] = wr_data[k];
                else m_err = 1'b1;
            end
            c_ok = wr_commit && (m_count < NB);
            r_ok = rd_release && (m_count > 0);
            if (wr_commit && !c_ok) m_err = 1'b1;
            if (rd_release && !r_ok) m_err = 1'b1;
            m_count = m_count + int'(c_ok) - int'(r_ok);
            if (r_ok) m_ptr = (m_ptr + 1) % NB;
            c_ok = c3_commit && (m3_count < 3);
            r_ok = c3_release && (m3_count > 0);
            m3_count = m3_count + int'(c_ok) - int'(r_ok);
            if (r_ok) m3_ptr = (m3_ptr + 1) % 3;
        end
        @(posedge clk); #1;
        reset = 1'b0; wr_valid = 1'b0; wr_commit = 1'b0; rd_en = 1'b0; rd_release = 1'b0;
        c3_commit = 1'b0; c3_release = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; step();
        checks++; if (wr_ready !== 1'b1) begin errors++; $display("FAIL reset_wr_ready got=%b exp=1", wr_ready); end
        checks++; if (rd_bank_ready !== 1'b0) begin errors++; $display("FAIL reset_rd_bank_ready got=%b exp=0", rd_bank_ready); end
        checks++; if (count !== 2'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err); end
        checks++; if (rd_data !== '0) begin errors++; $display("FAIL reset_rd_data got=%h exp=0", rd_data); end
        checks++; if ({fill_bank, read_bank, rd_valid} !== 3'b000) begin errors++; $display("FAIL reset_banks got=%b exp=000", {fill_bank, read_bank, rd_valid}); end
        rd_en = 1'b1; rd_addr = 4'd3; step();
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL empty_read_valid got=%b exp=0", rd_valid); end
        checks++; if (err !== 1'b1 || err !== m_err) begin errors++; $display("FAIL empty_read_err got=%b exp=1", err); end
        reset = 1'b1; step();
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_clear got=%b exp=0", err); end
    endtask

    task automatic test_fill_read();
        for (int r = 0; r < 16; r++) begin
            wr_valid = 1'b1; wr_addr = 4'(r);
            for (int k = 0; k < 4; k++) wr_data[k] = 8'(16 * r + k);
            wr_commit = (r == 15); step();
        end
        checks++; if (count !== 2'd1 || fill_bank !== 1'b1 || read_bank !== 1'b0) begin errors++;
            $display("FAIL commit0 got count=%0d fill=%0d read=%0d exp 1/1/0", count, fill_bank, read_bank); end
        mode = 1'b0; rd_en = 1'b1; rd_addr = 4'd5; step();
        checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL fc_valid got=%b exp=1", rd_valid); end
        checks++; if (rd_data !== exp_data) begin errors++; $display("FAIL fc_data got=%h exp=%h", rd_data, exp_data); end
        checks++; if (rd_data[1][2] !== 8'd82) begin errors++; $display("FAIL fc_elem got=%0d exp=82", rd_data[1][2]); end
        step();
        checks++; if (rd_valid !== 1'b0 || rd_data !== exp_data) begin errors++; $display("FAIL fc_hold got v=%b d=%h exp v=0 d=%h", rd_valid, rd_data, exp_data); end
        mode = 1'b1; rd_en = 1'b1; rd_addr = 4'd6; step();
        checks++; if (rd_data[0] !== {8'd99, 8'd98, 8'd97, 8'd96} || rd_data[3:1] !== '0) begin errors++;
            $display("FAIL cnn_data got=%h exp=636261 60 in row0 only", rd_data); end
        for (int n = 0; n < 8; n++) begin
            mode = 1'($urandom); rd_addr = 4'($urandom); rd_en = 1'b1; step();
            checks++; if (rd_valid !== exp_valid || rd_data !== exp_data) begin errors++;
                $display("FAIL rand_read%0d got v=%b d=%h exp v=%b d=%h", n, rd_valid, rd_data, exp_valid, exp_data); end
        end
    endtask

    task automatic test_overlap();
        for (int r = 0; r < 16; r++) begin
            wr_valid = 1'b1; wr_addr = 4'(r);
            for (int k = 0; k < 4; k++) wr_data[k] = 8'(8'h80 + r) ^ 8'($urandom & 8'h70);
            mode = 1'($urandom); rd_addr = 4'($urandom); rd_en = 1'b1;
            if (r == 15) begin wr_commit = 1'b1; rd_release = 1'b1; end
            step();
            checks++; if (rd_valid !== 1'b1 || rd_data !== exp_data) begin errors++;
                $display("FAIL overlap_read%0d got v=%b d=%h exp d=%h", r, rd_valid, rd_data, exp_data); end
        end
        checks++; if (count !== 2'd1 || read_bank !== 1'b1 || fill_bank !== 1'b0) begin errors++;
            $display("FAIL swap got count=%0d read=%0d fill=%0d exp 1/1/0", count, read_bank, fill_bank); end
        for (int n = 0; n < 4; n++) begin
            mode = 1'($urandom); rd_addr = 4'($urandom); rd_en = 1'b1; step();
            checks++; if (rd_valid !== 1'b1 || rd_data !== exp_data) begin errors++;
                $display("FAIL bank1_read%0d got d=%h exp d=%h", n, rd_data, exp_data); end
        end
    endtask

    task automatic test_full();
        for (int r = 0; r < 16; r++) begin
            wr_valid = 1'b1; wr_addr = 4'(r);
            for (int k = 0; k < 4; k++) wr_data[k] = 8'($urandom);
            wr_commit = (r == 15); step();
        end
        checks++; if (count !== 2'd2 || wr_ready !== 1'b0 || fill_bank !== 1'b1) begin errors++;
            $display("FAIL full got count=%0d wr_ready=%b fill=%0d exp 2/0/1", count, wr_ready, fill_bank); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL full_err_early got=%b exp=0", err); end
        wr_valid = 1'b1; wr_addr = 4'd3; wr_data = 32'h5A5A5A5A; step();
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL drop_err got=%b exp=1", err); end
        mode = 1'b1; rd_addr = 4'd3; rd_en = 1'b1; step();
        checks++; if (rd_data !== exp_data) begin errors++; $display("FAIL drop_readback got=%h exp=%h", rd_data, exp_data); end
        wr_commit = 1'b1; step();
        checks++; if (count !== 2'd2) begin errors++; $display("FAIL third_commit got=%0d exp=2", count); end
        rd_release = 1'b1; step();
        checks++; if (count !== 2'd1 || read_bank !== 1'b0) begin errors++; $display("FAIL release got count=%0d read=%0d exp 1/0", count, read_bank); end
        mode = 1'b0; rd_addr = 4'($urandom); rd_en = 1'b1; step();
        checks++; if (rd_data !== exp_data) begin errors++; $display("FAIL bank0_reread got=%h exp=%h", rd_data, exp_data); end
        rd_release = 1'b1; step();
        reset = 1'b1; step();
        rd_release = 1'b1; step();
        checks++; if (err !== 1'b1 || count !== 2'd0 || read_bank !== 1'b0) begin errors++;
            $display("FAIL empty_release got err=%b count=%0d read=%0d exp 1/0/0", err, count, read_bank); end
    endtask

    task automatic test_wrap();
        reset = 1'b1; step();
        for (int i = 0; i < 6; i++) begin
            checks++; if (read_bank_3 !== 2'(i % 3)) begin errors++; $display("FAIL wrap_read%0d got=%0d exp=%0d", i, read_bank_3, i % 3); end
            for (int c = 0; c < int'($urandom_range(1, 2)); c++) begin
                c3_commit = 1'b1; step();
                checks++; if (count_3 !== 2'(m3_count) || fill_bank_3 !== 2'((m3_ptr + m3_count) % 3)) begin errors++;
                    $display("FAIL wrap_commit%0d got count=%0d fill=%0d exp %0d/%0d", i, count_3, fill_bank_3, m3_count, (m3_ptr + m3_count) % 3); end
            end
            c3_release = 1'b1; step();
            checks++; if (read_bank_3 !== 2'(m3_ptr) || fill_bank_3 !== 2'((m3_ptr + m3_count) % 3)) begin errors++;
                $display("FAIL wrap_release%0d got read=%0d fill=%0d exp %0d/%0d", i, read_bank_3, fill_bank_3, m3_ptr, (m3_ptr + m3_count) % 3); end
        end
    endtask

    task automatic test_reset_mid();
        wr_commit = 1'b1; step();
        wr_commit = 1'b1; step();
        checks++; if (count !== 2'd2) begin errors++; $display("FAIL mid_setup got=%0d exp=2", count); end
        reset = 1'b1; rd_en = 1'b1; mode = 1'b0; rd_addr = 4'd0; step();
        checks++; if (count !== 2'd0 || rd_valid !== 1'b0 || err !== 1'b0 || rd_data !== '0) begin errors++;
            $display("FAIL mid_reset got count=%0d v=%b err=%b d=%h exp 0/0/0/0", count, rd_valid, err, rd_data); end
        step();
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL stale_valid got=%b exp=0", rd_valid); end
        wr_commit = 1'b1; step();
        mode = 1'b1; rd_addr = 4'd9; rd_en = 1'b1; step();
        checks++; if (rd_valid !== 1'b1 || rd_data !== exp_data) begin errors++;
            $display("FAIL storage_kept got v=%b d=%h exp v=1 d=%h", rd_valid, rd_data, exp_data); end
    endtask

    initial begin
        #1;
        test_reset();
        test_fill_read();
        test_overlap();
        test_full();
        test_wrap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "timeout");
    end

endmodule
